// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing a 2*WIDTH-bit product into HI/LO after WIDTH+1 cycles.
// Optional signed (MULT) support is built only when MULT_SIGNED_EN is defined.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] fator0,
  input  logic [WIDTH-1:0] fator1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_mag0;
  logic [WIDTH-1:0]   w_mag1;
  logic [2*WIDTH-1:0] w_product;

`ifdef MULT_SIGNED_EN
  logic w_sign0;
  logic w_sign1;
  logic r_neg;

  assign w_sign0 = is_signed & fator0[WIDTH-1];
  assign w_sign1 = is_signed & fator1[WIDTH-1];
  // The most-negative value negates to itself, which read as unsigned is its exact magnitude.
  assign w_mag0  = w_sign0 ? -fator0 : fator0;
  assign w_mag1  = w_sign1 ? -fator1 : fator1;
  assign w_product = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg <= w_sign0 ^ w_sign1;
    end
  end
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_mag0    = fator0;
  assign w_mag1    = fator1;
  assign w_product = r_acc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_count == CW'(WIDTH - 1)) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The multiplicand register shifts left each iteration, so it always holds mcand << count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag0};
            r_mplier <= w_mag1;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        S_FIN: begin
          r_hi   <= w_product[2*WIDTH-1:WIDTH];
          r_lo   <= w_product[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32) with a queue scoreboard of expected products.
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] fator0 = '0;
  logic [W-1:0] fator1 = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  logic [2*W-1:0] sb_q[$];
  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .fator0    (fator0),
    .fator1    (fator1),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
`ifdef MULT_SIGNED_EN
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
`endif
    sa = {{W{1'b0}}, a};
    sb = {{W{1'b0}}, b};
    return sa * sb;
  endfunction

  // Called at a negedge; the following posedge is the start edge, returns at the next negedge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic [2*W-1:0] exp, input bit push);
    fator0    = a;
    fator1    = b;
    is_signed = s;
    start     = 1'b1;
    if (push) sb_q.push_back(exp);
    $display("start a=%h b=%h signed=%0b expect=%h", a, b, s, exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches negedges after a start edge; optionally injects a stray start or a reset.
  task automatic run_wait(input int inj_start_at, input int inj_reset_at,
                          output bit got_done, output int lat, output int busy_cnt);
    int n;
    n = 1;
    got_done = 1'b0;
    busy_cnt = busy ? 1 : 0;
    while (n < 60) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = (n == inj_start_at);
      if (n == inj_start_at) begin
        fator0 = 1;
        fator1 = 1;
      end
      reset = (n == inj_reset_at);
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    reset = 1'b0;
    lat   = n - 1;
  endtask

  task automatic pop_check(input string tag);
    logic [2*W-1:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {HI, LO}, exp);
      $display("done %s HI=%h LO=%h", tag, HI, LO);
    end
  endtask

  initial begin
    bit got;
    int lat;
    int bcnt;

    repeat (2) @(negedge clk);
    check("reset_hilo", {HI, LO}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3 x 5 unsigned: latency, busy window, product, single-cycle done
    drive_start(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1);
    run_wait(0, 0, got, lat, bcnt);
    check("t1_done_seen", {63'd0, got}, 64'd1);
    check("t1_latency", 64'(lat), 64'd33);
    check("t1_busy_cycles", 64'(bcnt), 64'd33);
    pop_check("t1_3x5");
    @(negedge clk);
    check("t1_done_pulse", {63'd0, done}, 64'd0);

    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1);
    run_wait(0, 0, got, lat, bcnt);
    check("t2_latency", 64'(lat), 64'd33);
    pop_check("t2_max_unsigned");
    @(negedge clk);

`ifdef MULT_SIGNED_EN
    drive_start(32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1);
    run_wait(0, 0, got, lat, bcnt);
    pop_check("t3_neg2x3");
    @(negedge clk);
    drive_start(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1);
    run_wait(0, 0, got, lat, bcnt);
    pop_check("t3_minxmin");
    @(negedge clk);
`else
    drive_start(32'hFFFF_FFFE, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFFA, 1);
    run_wait(0, 0, got, lat, bcnt);
    pop_check("t4_signed_ignored");
    @(negedge clk);
`endif

    // 7 x 9 with an ignored start at cycle 10, then 2 x 2 started in the done cycle
    drive_start(32'd7, 32'd9, 1'b0, model(32'd7, 32'd9, 1'b0), 1);
    run_wait(10, 0, got, lat, bcnt);
    check("t5_latency", 64'(lat), 64'd33);
    pop_check("t5_7x9");
    drive_start(32'd2, 32'd2, 1'b0, model(32'd2, 32'd2, 1'b0), 1);
    check("t5_hold", {HI, LO}, 64'h3F);
    run_wait(0, 0, got, lat, bcnt);
    check("t5_chain_latency", 64'(lat), 64'd33);
    pop_check("t5_2x2");
    @(negedge clk);

    // 6 x 7 completes, 5 x 5 is aborted by reset at cycle 12, then 2 x 3
    drive_start(32'd6, 32'd7, 1'b0, model(32'd6, 32'd7, 1'b0), 1);
    run_wait(0, 0, got, lat, bcnt);
    pop_check("t6_6x7");
    @(negedge clk);
    drive_start(32'd5, 32'd5, 1'b0, 64'd0, 0);
    run_wait(0, 12, got, lat, bcnt);
    check("t6_no_done", {63'd0, got}, 64'd0);
    check("t6_abort_hilo", {HI, LO}, 64'd0);
    check("t6_abort_busy", {63'd0, busy}, 64'd0);
    drive_start(32'd2, 32'd3, 1'b0, model(32'd2, 32'd3, 1'b0), 1);
    run_wait(0, 0, got, lat, bcnt);
    check("t6_latency", 64'(lat), 64'd33);
    pop_check("t6_2x3");
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
